// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator. The block provides programmable H/V timing,
// selectable sync polarity and an integer pixel-clock divider. It also draws one rectangle over
// a solid RGB332 background. The overlay geometry is double-buffered and swaps only at frame
// boundaries.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 1,
   parameter int HW        = 11,
   parameter int VW        = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          cfg_load,
   input  logic [HW-1:0] rect_x0,
   input  logic [HW-1:0] rect_x1,
   input  logic [VW-1:0] rect_y0,
   input  logic [VW-1:0] rect_y1,
   input  logic [7:0]    fg_color,
   input  logic [7:0]    bg_color,
   output logic [HW-1:0] hcount,
   output logic [VW-1:0] vcount,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start,
   output logic [2:0]    red,
   output logic [2:0]    green,
   output logic [1:0]    blue
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > 2 ** HW) begin : g_bad_hw
      $error("vga_timing_gen: H_TOTAL does not fit in HW bits");
   end
   if (V_TOTAL > 2 ** VW) begin : g_bad_vw
      $error("vga_timing_gen: V_TOTAL does not fit in VW bits");
   end

   typedef struct packed {
      logic [HW-1:0] x0;
      logic [HW-1:0] x1;
      logic [VW-1:0] y0;
      logic [VW-1:0] y1;
      logic [7:0]    fg;
      logic [7:0]    bg;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{
      x0: HW'(100), x1: HW'(300), y0: VW'(100), y1: VW'(200), fg: 8'hE0, bg: 8'hFF
   };

   logic [DW-1:0] div_cnt;
   logic [HW-1:0] hc;
   logic [VW-1:0] vc;
   cfg_t          pend;
   cfg_t          live;
   logic          pend_valid;

   logic tick;
   logic h_last;
   logic v_last;
   logic frame_wrap;
   logic visible;
   logic in_hsync;
   logic in_vsync;
   logic in_rect;

   assign tick       = enable && (div_cnt == DW'(CLK_DIV - 1));
   assign h_last     = (hc == HW'(H_TOTAL - 1));
   assign v_last     = (vc == VW'(V_TOTAL - 1));
   assign frame_wrap = tick && h_last && v_last;

   // Decode the current raster position; int casts zero-extend so the bounds compare unsigned.
   always_comb begin
      visible  = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
      in_hsync = (int'(hc) >= HS_START) && (int'(hc) < HS_END);
      in_vsync = (int'(vc) >= VS_START) && (int'(vc) < VS_END);
      in_rect  = (hc >= live.x0) && (hc <= live.x1) && (vc >= live.y0) && (vc <= live.y1);
   end

   // Pixel divider and raster counters; everything freezes while enable is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         hc      <= '0;
         vc      <= '0;
      end else if (enable) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            if (h_last) begin
               hc <= '0;
               vc <= v_last ? '0 : vc + 1'b1;
            end else begin
               hc <= hc + 1'b1;
            end
         end
      end
   end

   // Shadow geometry: a load made on the wrap tick itself lands in pend and waits a frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend       <= CFG_RESET;
         live       <= CFG_RESET;
         pend_valid <= 1'b0;
      end else begin
         if (frame_wrap && pend_valid) begin
            live <= pend;
         end
         if (cfg_load) begin
            pend <= '{x0: rect_x0, x1: rect_x1, y0: rect_y0, y1: rect_y1,
                      fg: fg_color, bg: bg_color};
            pend_valid <= 1'b1;
         end else if (frame_wrap) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // Output stage: every pin is registered from hc/vc, so all outputs share one clk of latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount               <= '0;
         vcount               <= '0;
         active               <= 1'b0;
         hsync                <= ~HSYNC_POL;
         vsync                <= ~VSYNC_POL;
         frame_start          <= 1'b0;
         {red, green, blue}   <= 8'h00;
      end else begin
         hcount <= hc;
         vcount <= vc;
         if (enable) begin
            active      <= visible;
            hsync       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
            // Only the first clk of pixel (0,0) so the pulse is one clk wide for any divider.
            frame_start <= (hc == '0) && (vc == '0) && (div_cnt == '0);
            if (visible) begin
               {red, green, blue} <= in_rect ? live.fg : live.bg;
            end else begin
               {red, green, blue} <= 8'h00;
            end
         end else begin
            active             <= 1'b0;
            hsync              <= ~HSYNC_POL;
            vsync              <= ~VSYNC_POL;
            frame_start        <= 1'b0;
            {red, green, blue} <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster, with divide-by-2
// pixel clock and positive syncs, plus directed timing and pixel spot checks.
module tb_vga_timing_gen;

   localparam int H_ACTIVE  = 104;
   localparam int H_FP      = 2;
   localparam int H_SYNC    = 3;
   localparam int H_BP      = 2;
   localparam int V_ACTIVE  = 104;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 1;
   localparam bit HSYNC_POL = 1'b1;
   localparam bit VSYNC_POL = 1'b1;
   localparam int CLK_DIV   = 2;
   localparam int HW        = 11;
   localparam int VW        = 10;

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

   typedef struct packed {
      logic [HW-1:0] x0;
      logic [HW-1:0] x1;
      logic [VW-1:0] y0;
      logic [VW-1:0] y1;
      logic [7:0]    fg;
      logic [7:0]    bg;
   } cfg_t;

   typedef struct packed {
      logic [HW-1:0] hc;
      logic [VW-1:0] vc;
      logic          act;
      logic          hs;
      logic          vs;
      logic          fs;
      logic [7:0]    rgb;
   } obs_t;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] rgb;
   } pt_t;

   localparam cfg_t CFG_DEF = '{
      x0: HW'(100), x1: HW'(300), y0: VW'(100), y1: VW'(200), fg: 8'hE0, bg: 8'hFF
   };
   localparam obs_t RST_OBS = '{
      hc: '0, vc: '0, act: 1'b0, hs: ~HSYNC_POL, vs: ~VSYNC_POL, fs: 1'b0, rgb: 8'h00
   };

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          cfg_load = 1'b0;
   logic [HW-1:0] rect_x0 = '0;
   logic [HW-1:0] rect_x1 = '0;
   logic [VW-1:0] rect_y0 = '0;
   logic [VW-1:0] rect_y1 = '0;
   logic [7:0]    fg_color = 8'h00;
   logic [7:0]    bg_color = 8'h00;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          active;
   logic          hsync;
   logic          vsync;
   logic          frame_start;
   logic [2:0]    red;
   logic [2:0]    green;
   logic [1:0]    blue;

   int n_checks = 0;
   int n_fail   = 0;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HSYNC_POL(HSYNC_POL),
      .VSYNC_POL(VSYNC_POL),
      .CLK_DIV  (CLK_DIV),
      .HW       (HW),
      .VW       (VW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .cfg_load   (cfg_load),
      .rect_x0    (rect_x0),
      .rect_x1    (rect_x1),
      .rect_y0    (rect_y0),
      .rect_y1    (rect_y1),
      .fg_color   (fg_color),
      .bg_color   (bg_color),
      .hcount     (hcount),
      .vcount     (vcount),
      .active     (active),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_start(frame_start),
      .red        (red),
      .green      (green),
      .blue       (blue)
   );

   always #5 clk = ~clk;

   obs_t dut_obs;
   assign dut_obs = {hcount, vcount, active, hsync, vsync, frame_start, red, green, blue};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   int            m_div = 0;
   logic [HW-1:0] m_hc = '0;
   logic [VW-1:0] m_vc = '0;
   cfg_t          m_live = CFG_DEF;
   cfg_t          m_pend = CFG_DEF;
   logic          m_pflag = 1'b0;
   obs_t          exp_now;
   logic          m_tick;
   logic          m_wrap;
   obs_t          sb_q[$];

   function automatic logic [7:0] pix_color(input cfg_t c, input int x, input int y);
      if (x >= int'(c.x0) && x <= int'(c.x1) && y >= int'(c.y0) && y <= int'(c.y1)) begin
         return c.fg;
      end
      return c.bg;
   endfunction

   always_comb begin
      exp_now     = '0;
      exp_now.hc  = m_hc;
      exp_now.vc  = m_vc;
      exp_now.hs  = ~HSYNC_POL;
      exp_now.vs  = ~VSYNC_POL;
      if (enable) begin
         if (int'(m_hc) >= H_ACTIVE + H_FP && int'(m_hc) < H_ACTIVE + H_FP + H_SYNC) begin
            exp_now.hs = HSYNC_POL;
         end
         if (int'(m_vc) >= V_ACTIVE + V_FP && int'(m_vc) < V_ACTIVE + V_FP + V_SYNC) begin
            exp_now.vs = VSYNC_POL;
         end
         exp_now.act = (int'(m_hc) < H_ACTIVE) && (int'(m_vc) < V_ACTIVE);
         exp_now.fs  = (m_hc == 0) && (m_vc == 0) && (m_div == 0);
         if (exp_now.act) exp_now.rgb = pix_color(m_live, int'(m_hc), int'(m_vc));
      end
      m_tick = enable && (m_div == CLK_DIV - 1);
      m_wrap = m_tick && (int'(m_hc) == H_TOTAL - 1) && (int'(m_vc) == V_TOTAL - 1);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sb_q.delete();
         m_div   <= 0;
         m_hc    <= '0;
         m_vc    <= '0;
         m_live  <= CFG_DEF;
         m_pend  <= CFG_DEF;
         m_pflag <= 1'b0;
      end else begin
         sb_q.push_back(exp_now);
         if (enable) m_div <= m_tick ? 0 : m_div + 1;
         if (m_tick) begin
            if (int'(m_hc) == H_TOTAL - 1) begin
               m_hc <= '0;
               m_vc <= (int'(m_vc) == V_TOTAL - 1) ? '0 : m_vc + 1'b1;
            end else begin
               m_hc <= m_hc + 1'b1;
            end
         end
         if (m_wrap && m_pflag) m_live <= m_pend;
         if (cfg_load) begin
            m_pend  <= '{x0: rect_x0, x1: rect_x1, y0: rect_y0, y1: rect_y1,
                         fg: fg_color, bg: bg_color};
            m_pflag <= 1'b1;
         end else if (m_wrap) begin
            m_pflag <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin : sb_check
      obs_t e;
      if (!reset && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("outputs", dut_obs, e);
      end
   end

   // ---------------- directed checks ----------------
   pt_t                pts[$];
   int                 phase = 0;
   bit                 meas = 1'b0;
   bit                 stop = 1'b0;
   int                 hs_len = 0;
   int                 vs_len = 0;
   logic [HW+VW-1:0]   prev_pos = '0;

   task automatic add_pt(input int x, input int y, input logic [7:0] rgb);
      pt_t p;
      p.x   = x;
      p.y   = y;
      p.rgb = rgb;
      pts.push_back(p);
   endtask

   task automatic load_cfg(input int x0, input int x1, input int y0, input int y1,
                           input logic [7:0] fg, input logic [7:0] bg);
      rect_x0  = HW'(x0);
      rect_x1  = HW'(x1);
      rect_y0  = VW'(y0);
      rect_y1  = VW'(y1);
      fg_color = fg;
      bg_color = bg;
      cfg_load = 1'b1;
   endtask

   task automatic on_sample();
      logic [HW+VW-1:0] pos;
      bit               new_pix;
      pos      = {hcount, vcount};
      new_pix  = (pos != prev_pos);
      prev_pos = pos;
      cfg_load = 1'b0;
      if (new_pix) begin
         foreach (pts[i]) begin
            if (int'(hcount) == pts[i].x && int'(vcount) == pts[i].y) begin
               check_eq($sformatf("pix_%0d_%0d", pts[i].x, pts[i].y),
                        {red, green, blue}, pts[i].rgb);
            end
         end
      end
      if (meas) begin
         if (hsync == HSYNC_POL) begin
            if (hs_len == 0) check_eq("hsync_start_x", hcount, H_ACTIVE + H_FP);
            hs_len++;
         end else if (hs_len != 0) begin
            check_eq("hsync_width_clks", hs_len, H_SYNC * CLK_DIV);
            hs_len = 0;
         end
         if (vsync == VSYNC_POL) begin
            if (vs_len == 0) check_eq("vsync_start_y", vcount, V_ACTIVE + V_FP);
            vs_len++;
         end else if (vs_len != 0) begin
            check_eq("vsync_width_clks", vs_len, V_SYNC * H_TOTAL * CLK_DIV);
            vs_len = 0;
         end
      end
      // Two loads in one frame; only the second should reach the next frame.
      if (phase == 2 && new_pix && hcount == 0) begin
         if (vcount == 40) load_cfg(50, 60, 0, 9, 8'h1C, 8'hFF);
         else if (vcount == 50) load_cfg(0, 9, 0, 9, 8'h03, 8'hFF);
      end
      if (phase == 3 && new_pix) begin
         if (hcount == 50 && vcount == 12) begin
            enable = 1'b0;
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               check_eq("en_low_hcount", hcount, 50);
               check_eq("en_low_outputs", {active, hsync, vsync, frame_start, red, green, blue},
                        {1'b0, ~HSYNC_POL, ~VSYNC_POL, 1'b0, 8'h00});
            end
            enable = 1'b1;
         end else if (hcount == 60 && vcount == 15) begin
            #2 reset = 1'b1;
            #1 check_eq("async_reset", dut_obs, RST_OBS);
            stop = 1'b1;
         end
      end
   endtask

   task automatic run_frame(input bit meas_en, input bit check_period);
      int clks = 0;
      bit seen = 1'b0;
      hs_len = 0;
      vs_len = 0;
      stop   = 1'b0;
      meas   = meas_en;
      while (!seen && !stop && clks < FRAME_CLKS + 64) begin
         @(negedge clk);
         clks++;
         on_sample();
         if (frame_start) seen = 1'b1;
      end
      if (!stop) begin
         check_eq("frame_start_seen", seen, 1);
         if (check_period) check_eq("frame_period_clks", clks, FRAME_CLKS);
      end
      meas = 1'b0;
   endtask

   task automatic default_pts();
      pts.delete();
      add_pt(102, 102, 8'hE0);
      add_pt(100, 100, 8'hE0);
      add_pt(103, 103, 8'hE0);
      add_pt(99, 102, 8'hFF);
      add_pt(102, 99, 8'hFF);
      add_pt(104, 10, 8'h00);
      add_pt(10, 104, 8'h00);
   endtask

   initial begin
      #1 reset = 1'b1;
      #3 check_eq("reset_state", dut_obs, RST_OBS);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("fs_after_reset", frame_start, 1);
      prev_pos = {hcount, vcount};

      // Frame 1: default rectangle, sync timing, frame period.
      phase = 1;
      default_pts();
      run_frame(1'b1, 1'b1);

      // Frame 2: reloads mid-frame; the old rectangle must persist to the end of the frame.
      phase = 2;
      pts.delete();
      add_pt(102, 102, 8'hE0);
      add_pt(101, 100, 8'hE0);
      add_pt(5, 60, 8'hFF);
      run_frame(1'b0, 1'b1);

      // Frame 3: new rectangle live, enable pause, then asynchronous reset mid-frame.
      phase = 3;
      pts.delete();
      add_pt(1, 1, 8'h03);
      add_pt(5, 5, 8'h03);
      add_pt(9, 9, 8'h03);
      add_pt(10, 9, 8'hFF);
      add_pt(9, 10, 8'hFF);
      add_pt(55, 5, 8'hFF);
      run_frame(1'b0, 1'b0);
      check_eq("reset_test_reached", stop, 1);
      repeat (2) @(negedge clk);
      check_eq("reset_hold", dut_obs, RST_OBS);
      reset = 1'b0;
      @(negedge clk);
      check_eq("fs_after_mid_reset", frame_start, 1);
      prev_pos = {hcount, vcount};

      // Frame 4: default rectangle restored by reset.
      phase = 4;
      default_pts();
      run_frame(1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
